// File: rtl/core_mem_arbiter_pkg.sv
// core_mem_arbiter_pkg: opcode and FSM state types plus memory geometry shared by the arbiter slice.
package core_mem_arbiter_pkg;
  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 8;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_RSVD = 2'd3} opcode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} arb_state_t;
  function automatic logic is_mem_op(input opcode_t op);
    return op == OP_LOAD || op == OP_STORE;
  endfunction
endpackage

// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if: core request bus and memory port between the core array, arbiter and memory.
interface core_mem_arbiter_if
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic [NUM_CORES-1:0] req;
  opcode_t [NUM_CORES-1:0] core_op;
  logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr;
  logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0] gnt;
  logic [NUM_CORES-1:0] done;
  logic err;
  logic [DATA_W-1:0] rdata;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_ack;
  modport slave (
    input  req, core_op, core_addr, core_wdata, mem_rdata, mem_ack,
    output gnt, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req, core_op, core_addr, core_wdata, mem_rdata, mem_ack,
    input  gnt, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/core_mem_arbiter_rr_pick.sv
// core_mem_arbiter_rr_pick: combinational round-robin picker; first set request after i_ptr, wrapping.
module core_mem_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_oh,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] w_k;
  // Scan farthest-to-nearest so the nearest request after the pointer is the last to win.
  always_comb begin
    o_idx = '0;
    w_k = '0;
    for (int i = N; i >= 1; i--) begin
      w_k = IW'((int'(i_ptr) + i) % N);
      if (i_req[w_k]) o_idx = w_k;
    end
    o_oh = |i_req ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter sharing one memory port among NUM_CORES cores.
// Define ARB_TIMEOUT_EN to abort an ACCESS with err after TIMEOUT_CYC cycles without mem_ack.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input logic clk,
  input logic rst_n,
  core_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CORES);
  arb_state_t r_state, w_state;
  logic [IW-1:0] r_ptr, w_ptr, r_idx, w_idx, w_pick_idx;
  logic [NUM_CORES-1:0] r_gnt, w_gnt, r_done, w_done, w_pick_oh, w_req;
  logic r_bad, w_bad, r_err, w_err, r_mem_en, w_mem_en, r_mem_we, w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata, r_rdata, w_rdata;
  opcode_t w_op;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt, w_cnt;
`endif
  // The core just signalled done still holds req this cycle; it is not a new request yet.
  assign w_req = bus.req & ~r_done;
  core_mem_arbiter_rr_pick #(.N(NUM_CORES)) u_pick (
    .i_req(w_req),
    .i_ptr(r_ptr),
    .o_oh (w_pick_oh),
    .o_idx(w_pick_idx)
  );
  assign w_op = bus.core_op[w_pick_idx];
  always_comb begin
    w_state = r_state;
    w_ptr = r_ptr;
    w_idx = r_idx;
    w_gnt = r_gnt;
    w_done = '0;
    w_bad = r_bad;
    w_err = 1'b0;
    w_mem_en = r_mem_en;
    w_mem_we = r_mem_we;
    w_mem_addr = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_rdata = r_rdata;
`ifdef ARB_TIMEOUT_EN
    w_cnt = r_cnt;
`endif
    case (r_state)
      IDLE: if (|w_req) begin
        w_idx = w_pick_idx;
        w_gnt = w_pick_oh;
        w_mem_addr = bus.core_addr[w_pick_idx];
        w_mem_wdata = bus.core_wdata[w_pick_idx];
        w_mem_en = is_mem_op(w_op);
        w_mem_we = w_op == OP_STORE;
        w_bad = !is_mem_op(w_op);
        w_state = is_mem_op(w_op) ? ACCESS : RESP;
`ifdef ARB_TIMEOUT_EN
        w_cnt = '0;
`endif
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          w_rdata = r_mem_we ? r_rdata : bus.mem_rdata;
          w_gnt = '0;
          w_mem_en = 1'b0;
          w_state = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_gnt = '0;
          w_mem_en = 1'b0;
          w_bad = 1'b1;
          w_state = RESP;
        end else w_cnt = r_cnt + 1'b1;
`endif
      end
      RESP: begin
        w_done = NUM_CORES'(1) << r_idx;
        w_err = r_bad;
        w_gnt = '0;
        w_ptr = r_idx;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= IW'(NUM_CORES - 1);
      r_idx <= '0;
      r_gnt <= '0;
      r_done <= '0;
      r_bad <= 1'b0;
      r_err <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_ptr <= w_ptr;
      r_idx <= w_idx;
      r_gnt <= w_gnt;
      r_done <= w_done;
      r_bad <= w_bad;
      r_err <= w_err;
      r_mem_en <= w_mem_en;
      r_mem_we <= w_mem_we;
      r_mem_addr <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_rdata <= w_rdata;
`ifdef ARB_TIMEOUT_EN
      r_cnt <= w_cnt;
`endif
    end
  end
  assign bus.gnt = r_gnt;
  assign bus.done = r_done;
  assign bus.err = r_err;
  assign bus.rdata = r_rdata;
  assign bus.mem_en = r_mem_en;
  assign bus.mem_we = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed scenarios then randomized traffic checked against a transaction-level model.
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;
  localparam int N = 4;
  typedef enum {M_IDLE, M_GNT, M_ACC, M_DONE} mode_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  core_mem_arbiter_if #(.NUM_CORES(N)) bus ();
  core_mem_arbiter #(.NUM_CORES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.req = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      bus.core_op[i] = OP_NOP;
      bus.core_addr[i] = '0;
      bus.core_wdata[i] = '0;
    end
  endtask
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic set_core(input int c, input opcode_t op, input logic [11:0] a, input logic [7:0] d);
    bus.req[c] = 1'b1;
    bus.core_op[c] = op;
    bus.core_addr[c] = a;
    bus.core_wdata[c] = d;
  endtask
  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction
  function automatic int gidx(input logic [N-1:0] v);
    gidx = -1;
    for (int i = 0; i < N; i++) if (v[i]) gidx = i;
  endfunction
  function automatic opcode_t pick_op();
    int r;
    r = int'($urandom_range(0, 9));
    return r < 4 ? OP_LOAD : r < 8 ? OP_STORE : r == 8 ? OP_NOP : OP_RSVD;
  endfunction
  mode_t mode;
  int g_who[$];
  int g_cyc[$];
  int hi, w, last, acc_wait, n_txn;
  logic legal, we_exp, exp_err, found;
  logic [1:0] k2;
  logic [11:0] a_exp;
  logic [7:0] d_exp, exp_rdata;
  logic [N-1:0] elig;
  logic [7:0] mem [4096];
  initial begin
    do_reset();
    check("reset_ctl", {bus.gnt, bus.done, bus.err, bus.mem_en, bus.mem_we}, 0);
    check("reset_data", {bus.rdata, bus.mem_addr, bus.mem_wdata}, 0);
    // single LOAD
    set_core(1, OP_LOAD, 12'h011, 8'h00);
    tick;
    check("t1_gnt", bus.gnt, 4'b0010);
    check("t1_en_we", {bus.mem_en, bus.mem_we}, 2'b10);
    check("t1_addr", bus.mem_addr, 12'h011);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'hA5;
    tick;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    check("t1_resp", {bus.gnt, bus.done, bus.mem_en}, 0);
    tick;
    check("t1_done", bus.done, 4'b0010);
    check("t1_err", bus.err, 0);
    check("t1_rdata", bus.rdata, 8'hA5);
    bus.req[1] = 1'b0;
    tick;
    check("t1_pulse", bus.done, 0);
    // STORE with delayed ack; core inputs change after grant
    set_core(2, OP_STORE, 12'h3FF, 8'hFE);
    tick;
    for (int k = 0; k < 3; k++) begin
      check("t2_hold", {bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {4'b0100, 2'b11, 12'h3FF, 8'hFE});
      bus.core_addr[2] = 12'h000;
      bus.core_wdata[2] = 8'h00;
      bus.mem_ack = (k == 2);
      bus.mem_rdata = 8'h5A;
      tick;
    end
    bus.mem_ack = 1'b0;
    check("t2_resp", {bus.gnt, bus.mem_en, bus.done}, 0);
    tick;
    check("t2_done", {bus.done, bus.err}, {4'b0100, 1'b0});
    check("t2_rdata", bus.rdata, 8'hA5);
    bus.req[2] = 1'b0;
    // contention, all cores keep re-requesting
    do_reset();
    for (int c = 0; c < N; c++) set_core(c, OP_LOAD, 12'(c), 8'h00);
    for (int k = 1; k <= 15; k++) begin
      tick;
      if (bus.gnt != 0) begin
        g_who.push_back(gidx(bus.gnt));
        g_cyc.push_back(k);
      end
      bus.mem_ack = |bus.gnt;
    end
    bus.mem_ack = 1'b0;
    bus.req = '0;
    check("t3_count", g_who.size(), 5);
    for (int k = 0; k < g_who.size(); k++) check("t3_order", g_who[k], k % N);
    for (int k = 1; k < g_cyc.size(); k++) check("t3_period", g_cyc[k] - g_cyc[k-1], 3);
    // illegal opcode
    do_reset();
    set_core(3, OP_RSVD, 12'h0AB, 8'h11);
    tick;
    check("t4_gnt", {bus.gnt, bus.mem_en}, {4'b1000, 1'b0});
    tick;
    check("t4_done", {bus.done, bus.err, bus.mem_en}, {4'b1000, 1'b1, 1'b0});
    bus.req[3] = 1'b0;
    tick;
    check("t4_pulse", {bus.done, bus.err}, 0);
    // reset in the middle of an access
    set_core(0, OP_LOAD, 12'h123, 8'h00);
    tick;
    check("t5_gnt", bus.gnt, 4'b0001);
    #2 rst_n = 1'b0;
    #1 check("t5_async", {bus.gnt, bus.done, bus.err, bus.mem_en, bus.mem_addr}, 0);
    @(posedge clk);
    #1 check("t5_held", {bus.gnt, bus.done, bus.mem_en}, 0);
    #4 rst_n = 1'b1;
    tick;
    check("t5_regrant", {bus.gnt, bus.done}, {4'b0001, 4'b0000});
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h3C;
    tick;
    bus.mem_ack = 1'b0;
    tick;
    check("t5_done", {bus.done, bus.rdata}, {4'b0001, 8'h3C});
    bus.req[0] = 1'b0;
    // memory never acknowledges
    set_core(1, OP_LOAD, 12'h055, 8'h00);
    hi = 0;
`ifdef ARB_TIMEOUT_EN
    tick;
    if (bus.gnt != 0) hi++;
    for (int k = 0; k < 40 && bus.done == 0; k++) begin
      tick;
      if (bus.gnt != 0) hi++;
    end
    check("t6_access_cycles", hi, 16);
    check("t6_done", {bus.done, bus.err, bus.rdata}, {4'b0010, 1'b1, 8'h3C});
`else
    for (int k = 0; k < 40; k++) begin
      tick;
      if (bus.gnt == 4'b0010 && bus.done == 0) hi++;
    end
    check("t6_gnt_held", hi, 40);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h77;
    tick;
    bus.mem_ack = 1'b0;
    tick;
    check("t6_done", {bus.done, bus.err, bus.rdata}, {4'b0010, 1'b0, 8'h77});
`endif
    bus.req[1] = 1'b0;
    // randomized traffic
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    do_reset();
    mode = M_IDLE;
    last = N - 1;
    exp_rdata = 8'h00;
    n_txn = 0;
    acc_wait = 0;
    w = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick;
      case (mode)
        M_GNT: begin
          check("rnd_gnt", {bus.gnt, bus.mem_en, bus.done}, {oh(w), legal, 4'b0000});
          if (legal) check("rnd_req", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {we_exp, a_exp, d_exp});
          exp_err = !legal;
          mode = legal ? M_ACC : M_DONE;
        end
        M_ACC: if (bus.mem_ack) begin
          check("rnd_release", {bus.gnt, bus.mem_en, bus.done}, 0);
          mode = M_DONE;
        end else check("rnd_hold", {bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {oh(w), 1'b1, we_exp, a_exp, d_exp});
        M_DONE: begin
          check("rnd_done", {bus.gnt, bus.done, bus.err, bus.rdata}, {4'b0000, oh(w), exp_err, exp_rdata});
          last = w;
          n_txn++;
          mode = M_IDLE;
        end
        default: check("rnd_idle", {bus.gnt, bus.done}, 0);
      endcase
      if (mode == M_ACC) begin
        bus.mem_ack = acc_wait >= 8 || $urandom_range(0, 2) == 0;
        bus.mem_rdata = mem[a_exp];
        acc_wait++;
        if (bus.mem_ack && we_exp) mem[a_exp] = d_exp;
        if (bus.mem_ack && !we_exp) exp_rdata = mem[a_exp];
      end else begin
        bus.mem_ack = $urandom_range(0, 3) == 0;
        bus.mem_rdata = 8'($urandom);
      end
      for (int c = 0; c < N; c++) begin
        if (bus.done[c]) begin
          if ($urandom_range(0, 1) == 1) set_core(c, pick_op(), 12'($urandom_range(0, 31)), 8'($urandom));
          else bus.req[c] = 1'b0;
        end else if (!bus.req[c] && $urandom_range(0, 3) == 0)
          set_core(c, pick_op(), 12'($urandom_range(0, 31)), 8'($urandom));
      end
      if (mode == M_IDLE) begin
        elig = bus.req & ~bus.done;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
          k2 = 2'((last + i) % N);
          if (!found && elig[k2]) begin
            w = int'(k2);
            found = 1'b1;
          end
        end
        if (found) begin
          legal = bus.core_op[w] == OP_LOAD || bus.core_op[w] == OP_STORE;
          we_exp = bus.core_op[w] == OP_STORE;
          a_exp = bus.core_addr[w];
          d_exp = bus.core_wdata[w];
          acc_wait = 0;
          mode = M_GNT;
        end
      end
    end
    check("rnd_traffic", n_txn > 200, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
